// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer fed by the ID->ROB stage.
// Entries are allocated in program order, completed out of order by tag and
// retired in order from the head.
// Optional feature macro: ROB_OPERAND_LOOKUP_EN adds two combinational operand
// lookup ports that see stored results plus a same-cycle writeback bypass.
module reorder_buffer #(
    parameter int ROB_DEPTH_LOG2     = 4,
    parameter int RF_ADDR_BUS_WIDTH  = 5,
    parameter int EXC_TYPE_BUS_WIDTH = 8,
    parameter int ADDR_BUS_WIDTH     = 32,
    parameter int DATA_BUS_WIDTH     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          alloc_en,
    output logic                          alloc_ready,
    output logic [ROB_DEPTH_LOG2-1:0]     alloc_tag,
    input  logic                          reg_write_en_in,
    input  logic [RF_ADDR_BUS_WIDTH-1:0]  reg_write_addr_in,
    input  logic [EXC_TYPE_BUS_WIDTH-1:0] exception_type_in,
    input  logic                          is_delayslot_in,
    input  logic [ADDR_BUS_WIDTH-1:0]     pc_in,
    input  logic                          wb_en,
    input  logic [ROB_DEPTH_LOG2-1:0]     wb_tag,
    input  logic [DATA_BUS_WIDTH-1:0]     wb_data,
    input  logic [EXC_TYPE_BUS_WIDTH-1:0] wb_exception_type,
    output logic                          commit_valid,
    input  logic                          commit_ack,
    output logic                          commit_reg_write_en,
    output logic [RF_ADDR_BUS_WIDTH-1:0]  commit_reg_write_addr,
    output logic [DATA_BUS_WIDTH-1:0]     commit_data,
    output logic [EXC_TYPE_BUS_WIDTH-1:0] commit_exception_type,
    output logic                          commit_is_delayslot,
    output logic [ADDR_BUS_WIDTH-1:0]     commit_pc,
    output logic [ROB_DEPTH_LOG2:0]       count,
    input  logic [ROB_DEPTH_LOG2-1:0]     lookup_tag_1,
    input  logic [ROB_DEPTH_LOG2-1:0]     lookup_tag_2,
    output logic                          lookup_ready_1,
    output logic                          lookup_ready_2,
    output logic [DATA_BUS_WIDTH-1:0]     lookup_data_1,
    output logic [DATA_BUS_WIDTH-1:0]     lookup_data_2
);

    localparam int DEPTH = 1 << ROB_DEPTH_LOG2;
    localparam logic [ROB_DEPTH_LOG2:0] PTR_ONE = 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    logic [ROB_DEPTH_LOG2:0]   head_ptr, tail_ptr;
    logic [ROB_DEPTH_LOG2-1:0] head_idx, tail_idx;
    logic [DEPTH-1:0]          valid_q, done_q;

    logic                          rwe_q   [DEPTH];
    logic [RF_ADDR_BUS_WIDTH-1:0]  raddr_q [DEPTH];
    logic [EXC_TYPE_BUS_WIDTH-1:0] exc_q   [DEPTH];
    logic                          dly_q   [DEPTH];
    logic [ADDR_BUS_WIDTH-1:0]     pc_q    [DEPTH];
    logic [DATA_BUS_WIDTH-1:0]     data_q  [DEPTH];

    logic full;
    logic alloc_fire, wb_fire, commit_fire;

    assign head_idx = head_ptr[ROB_DEPTH_LOG2-1:0];
    assign tail_idx = tail_ptr[ROB_DEPTH_LOG2-1:0];
    assign full     = (head_idx == tail_idx) && (head_ptr[ROB_DEPTH_LOG2] != tail_ptr[ROB_DEPTH_LOG2]);

    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;
    assign count       = tail_ptr - head_ptr;

    assign alloc_fire   = alloc_en && !full;
    assign wb_fire      = wb_en && valid_q[wb_tag];
    assign commit_valid = valid_q[head_idx] && done_q[head_idx];
    assign commit_fire  = commit_valid && commit_ack;

    // Pointer and status-bit bookkeeping; later assignments win, so allocation overrides the rest
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            valid_q  <= '0;
            done_q   <= '0;
        end else begin
            if (wb_fire) begin
                done_q[wb_tag] <= 1'b1;
            end
            if (commit_fire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                head_ptr          <= head_ptr + PTR_ONE;
            end
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail_ptr          <= tail_ptr + PTR_ONE;
            end
        end
    end

    // Entry payload; stale payload is harmless because every reader is gated by valid/done
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (wb_fire) begin
                data_q[wb_tag] <= wb_data;
                exc_q[wb_tag]  <= exc_q[wb_tag] | wb_exception_type;
            end
            if (alloc_fire) begin
                rwe_q[tail_idx]   <= reg_write_en_in;
                raddr_q[tail_idx] <= reg_write_addr_in;
                exc_q[tail_idx]   <= exception_type_in;
                dly_q[tail_idx]   <= is_delayslot_in;
                pc_q[tail_idx]    <= pc_in;
                data_q[tail_idx]  <= '0;
            end
        end
    end

    assign commit_reg_write_en   = commit_valid ? rwe_q[head_idx]   : 1'b0;
    assign commit_reg_write_addr = commit_valid ? raddr_q[head_idx] : '0;
    assign commit_data           = commit_valid ? data_q[head_idx]  : '0;
    assign commit_exception_type = commit_valid ? exc_q[head_idx]   : '0;
    assign commit_is_delayslot   = commit_valid ? dly_q[head_idx]   : 1'b0;
    assign commit_pc             = commit_valid ? pc_q[head_idx]    : '0;

`ifdef ROB_OPERAND_LOOKUP_EN
    // Operand lookup: a same-cycle writeback to the looked-up tag beats the stored result
    always_comb begin
        lookup_ready_1 = 1'b0;
        lookup_data_1  = '0;
        lookup_ready_2 = 1'b0;
        lookup_data_2  = '0;
        if (wb_fire && (wb_tag == lookup_tag_1)) begin
            lookup_ready_1 = 1'b1;
            lookup_data_1  = wb_data;
        end else if (valid_q[lookup_tag_1] && done_q[lookup_tag_1]) begin
            lookup_ready_1 = 1'b1;
            lookup_data_1  = data_q[lookup_tag_1];
        end
        if (wb_fire && (wb_tag == lookup_tag_2)) begin
            lookup_ready_2 = 1'b1;
            lookup_data_2  = wb_data;
        end else if (valid_q[lookup_tag_2] && done_q[lookup_tag_2]) begin
            lookup_ready_2 = 1'b1;
            lookup_data_2  = data_q[lookup_tag_2];
        end
    end
`else
    logic unused_lookup_tags;
    assign unused_lookup_tags = ^{lookup_tag_1, lookup_tag_2};
    assign lookup_ready_1 = 1'b0;
    assign lookup_ready_2 = 1'b0;
    assign lookup_data_1  = '0;
    assign lookup_data_2  = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus a randomized run of reorder_buffer
// against a queue-based model of in-order allocation and retirement.
module tb_reorder_buffer;

    localparam int L = 4;
    localparam int D = 16;
`ifdef ROB_OPERAND_LOOKUP_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, alloc_en, alloc_ready;
    logic [3:0]  alloc_tag;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [7:0]  exception_type_in;
    logic        is_delayslot_in;
    logic [31:0] pc_in;
    logic        wb_en;
    logic [3:0]  wb_tag;
    logic [31:0] wb_data;
    logic [7:0]  wb_exception_type;
    logic        commit_valid, commit_ack, commit_reg_write_en, commit_is_delayslot;
    logic [4:0]  commit_reg_write_addr;
    logic [31:0] commit_data, commit_pc;
    logic [7:0]  commit_exception_type;
    logic [4:0]  count;
    logic [3:0]  lookup_tag_1, lookup_tag_2;
    logic        lookup_ready_1, lookup_ready_2;
    logic [31:0] lookup_data_1, lookup_data_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_en(alloc_en), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
        .exception_type_in(exception_type_in), .is_delayslot_in(is_delayslot_in), .pc_in(pc_in),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .wb_exception_type(wb_exception_type),
        .commit_valid(commit_valid), .commit_ack(commit_ack),
        .commit_reg_write_en(commit_reg_write_en), .commit_reg_write_addr(commit_reg_write_addr),
        .commit_data(commit_data), .commit_exception_type(commit_exception_type),
        .commit_is_delayslot(commit_is_delayslot), .commit_pc(commit_pc),
        .count(count),
        .lookup_tag_1(lookup_tag_1), .lookup_tag_2(lookup_tag_2),
        .lookup_ready_1(lookup_ready_1), .lookup_ready_2(lookup_ready_2),
        .lookup_data_1(lookup_data_1), .lookup_data_2(lookup_data_2)
    );

    // Reference model: program-ordered queue of live instructions; tag = position offset from head
    typedef struct {
        logic        rwe;
        logic [4:0]  raddr;
        logic [7:0]  exc;
        logic        dly;
        logic [31:0] pc;
        logic        done;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   head_tag = 0;

    task automatic model_tick();
        ent_t e;
        bit   do_commit;
        bit   do_alloc;
        int   idx;
        if (rst || flush) begin
            mq.delete();
            head_tag = 0;
        end else begin
            do_commit = (mq.size() > 0) && mq[0].done && commit_ack;
            do_alloc  = alloc_en && (mq.size() < D);
            idx = (int'(wb_tag) - head_tag + D) % D;
            if (wb_en && idx < mq.size()) begin
                e = mq[idx];
                e.done = 1'b1;
                e.data = wb_data;
                e.exc  = e.exc | wb_exception_type;
                mq[idx] = e;
            end
            if (do_commit) begin
                void'(mq.pop_front());
                head_tag = (head_tag + 1) % D;
            end
            if (do_alloc) begin
                e.rwe = reg_write_en_in; e.raddr = reg_write_addr_in; e.exc = exception_type_in;
                e.dly = is_delayslot_in; e.pc = pc_in; e.done = 1'b0; e.data = 32'h0;
                mq.push_back(e);
            end
        end
    endtask

    task automatic model_lookup(input logic [3:0] tag, output logic rdy, output logic [31:0] dat);
        int idx;
        rdy = 1'b0;
        dat = 32'h0;
        if (LK) begin
            idx = (int'(tag) - head_tag + D) % D;
            if (idx < mq.size()) begin
                if (wb_en && wb_tag == tag) begin
                    rdy = 1'b1;
                    dat = wb_data;
                end else if (mq[idx].done) begin
                    rdy = 1'b1;
                    dat = mq[idx].data;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; alloc_en = 0; commit_ack = 0; wb_en = 0;
        reg_write_en_in = 0; reg_write_addr_in = 0; exception_type_in = 0;
        is_delayslot_in = 0; pc_in = 0; wb_tag = 0; wb_data = 0; wb_exception_type = 0;
        lookup_tag_1 = 0; lookup_tag_2 = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
        #1;
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic [7:0] exc);
        alloc_en = 1; pc_in = pc; exception_type_in = exc;
        reg_write_en_in = 1; reg_write_addr_in = pc[6:2]; is_delayslot_in = pc[2];
        cycle();
        alloc_en = 0;
        #1;
    endtask

    task automatic do_wb(input logic [3:0] tag, input logic [31:0] data, input logic [7:0] exc);
        wb_en = 1; wb_tag = tag; wb_data = data; wb_exception_type = exc;
        cycle();
        wb_en = 0; wb_exception_type = 0;
        #1;
    endtask

    task automatic do_commit();
        commit_ack = 1;
        cycle();
        commit_ack = 0;
        #1;
    endtask

    task automatic test_reset();
        alloc_en = 1; wb_en = 1; commit_ack = 1;
        rst = 1;
        cycle();
        idle();
        #1;
        checks++; if (count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_alloc_ready got %0b expected 1", alloc_ready); end
        checks++; if (alloc_tag !== 4'd0) begin errors++; $display("[TB] FAIL reset_alloc_tag got %0d expected 0", alloc_tag); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit_valid got %0b expected 0", commit_valid); end
        checks++; if ({commit_pc, commit_data, commit_exception_type} !== 72'h0) begin errors++; $display("[TB] FAIL reset_commit_fields got %h expected 0", {commit_pc, commit_data, commit_exception_type}); end
        checks++; if ({lookup_ready_1, lookup_ready_2, lookup_data_1, lookup_data_2} !== 66'h0) begin errors++; $display("[TB] FAIL reset_lookup got %h expected 0", {lookup_ready_1, lookup_ready_2, lookup_data_1, lookup_data_2}); end
    endtask

    task automatic test_in_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (alloc_tag !== 4'(i)) begin errors++; $display("[TB] FAIL in_order_tag got %0d expected %0d", alloc_tag, i); end
            do_alloc(32'h100 + 32'(4 * i), 8'h0);
        end
        checks++; if (count !== 5'd3) begin errors++; $display("[TB] FAIL in_order_count got %0d expected 3", count); end
        do_wb(4'd1, 32'hAA, 8'h0);
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL in_order_not_head got %0b expected 0", commit_valid); end
        do_wb(4'd0, 32'h55, 8'h0);
        checks++; if ({commit_valid, commit_pc, commit_data} !== {1'b1, 32'h100, 32'h55}) begin errors++; $display("[TB] FAIL in_order_first got %0b/%h/%h expected 1/100/55", commit_valid, commit_pc, commit_data); end
        do_commit();
        checks++; if ({commit_valid, commit_pc, commit_data} !== {1'b1, 32'h104, 32'hAA}) begin errors++; $display("[TB] FAIL in_order_second got %0b/%h/%h expected 1/104/aa", commit_valid, commit_pc, commit_data); end
        do_commit();
        checks++; if (count !== 5'd1 || commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL in_order_after got count %0d valid %0b expected 1/0", count, commit_valid); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < D; i++) do_alloc(32'h1000 + 32'(4 * i), 8'h0);
        checks++; if (count !== 5'd16 || alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_state got count %0d ready %0b expected 16/0", count, alloc_ready); end
        do_alloc(32'hDEAD, 8'h0);
        checks++; if (count !== 5'd16 || alloc_tag !== 4'd0) begin errors++; $display("[TB] FAIL full_extra_alloc got count %0d tag %0d expected 16/0", count, alloc_tag); end
        do_wb(4'd0, 32'h1, 8'h0);
        checks++; if (commit_pc !== 32'h1000) begin errors++; $display("[TB] FAIL full_head_pc got %h expected 1000", commit_pc); end
        do_commit();
        checks++; if (alloc_ready !== 1'b1 || count !== 5'd15) begin errors++; $display("[TB] FAIL full_after_commit got ready %0b count %0d expected 1/15", alloc_ready, count); end
        checks++; if (alloc_tag !== 4'd0) begin errors++; $display("[TB] FAIL wrap_tag got %0d expected 0", alloc_tag); end
        do_alloc(32'h2000, 8'h0);
        for (int i = 1; i < D; i++) do_wb(4'(i), 32'(i), 8'h0);
        for (int i = 1; i < D; i++) begin
            checks++; if (commit_pc !== 32'h1000 + 32'(4 * i)) begin errors++; $display("[TB] FAIL wrap_drain_pc got %h expected %h", commit_pc, 32'h1000 + 32'(4 * i)); end
            do_commit();
        end
        checks++; if (count !== 5'd1) begin errors++; $display("[TB] FAIL wrap_drained_count got %0d expected 1", count); end
        for (int i = 1; i < D; i++) begin
            checks++; if (alloc_tag !== 4'(i)) begin errors++; $display("[TB] FAIL wrap_tag got %0d expected %0d", alloc_tag, i); end
            do_alloc(32'h2000 + 32'(4 * i), 8'h0);
        end
        checks++; if (count !== 5'd16 || alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL wrap_full got count %0d ready %0b expected 16/0", count, alloc_ready); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc(32'h200 + 32'(4 * i), 8'h0);
        do_wb(4'd0, 32'h77, 8'h0);
        alloc_en = 1; pc_in = 32'h214; commit_ack = 1;
        cycle();
        alloc_en = 0; commit_ack = 0;
        #1;
        checks++; if (count !== 5'd5) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 5", count); end
        checks++; if (alloc_tag !== 4'd6) begin errors++; $display("[TB] FAIL b2b_tail got %0d expected 6", alloc_tag); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_head_valid got %0b expected 0", commit_valid); end
        do_wb(4'd1, 32'h88, 8'h0);
        checks++; if (commit_pc !== 32'h204 || commit_data !== 32'h88) begin errors++; $display("[TB] FAIL b2b_head got %h/%h expected 204/88", commit_pc, commit_data); end
    endtask

    task automatic test_exception_or();
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(32'h300 + 32'(4 * i), (i == 3) ? 8'h02 : 8'h00);
        for (int i = 0; i < 3; i++) do_wb(4'(i), 32'(i), 8'h0);
        do_wb(4'd3, 32'hC3, 8'h10);
        for (int i = 0; i < 3; i++) do_commit();
        checks++; if (commit_exception_type !== 8'h12 || commit_pc !== 32'h30C) begin errors++; $display("[TB] FAIL exc_or got %h pc %h expected 12 pc 30c", commit_exception_type, commit_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 7; i++) do_alloc(32'h400 + 32'(4 * i), 8'h0);
        do_wb(4'd0, 32'h5, 8'h0);
        flush = 1; alloc_en = 1; wb_en = 1; wb_tag = 4'd1; commit_ack = 1;
        cycle();
        idle();
        #1;
        checks++; if ({count, commit_valid, alloc_tag, alloc_ready} !== {5'd0, 1'b0, 4'd0, 1'b1}) begin errors++; $display("[TB] FAIL flush_state got count %0d valid %0b tag %0d ready %0b expected 0/0/0/1", count, commit_valid, alloc_tag, alloc_ready); end
        for (int i = 0; i < 3; i++) do_alloc(32'h500 + 32'(4 * i), 8'h0);
        do_wb(4'd0, 32'h6, 8'h0);
        rst = 1; alloc_en = 1; commit_ack = 1;
        cycle();
        idle();
        #1;
        checks++; if ({count, commit_valid, alloc_tag, alloc_ready} !== {5'd0, 1'b0, 4'd0, 1'b1}) begin errors++; $display("[TB] FAIL rst_mid_state got count %0d valid %0b tag %0d ready %0b expected 0/0/0/1", count, commit_valid, alloc_tag, alloc_ready); end
    endtask

    task automatic test_lookup();
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(32'h600 + 32'(4 * i), 8'h0);
        do_wb(4'd0, 32'h99, 8'h0);
        lookup_tag_1 = 4'd2; lookup_tag_2 = 4'd3;
        wb_en = 1; wb_tag = 4'd2; wb_data = 32'h1234;
        #1;
        checks++; if (lookup_ready_1 !== LK || lookup_data_1 !== (LK ? 32'h1234 : 32'h0)) begin errors++; $display("[TB] FAIL lookup_bypass got %0b/%h expected %0b/%h", lookup_ready_1, lookup_data_1, LK, LK ? 32'h1234 : 32'h0); end
        checks++; if (lookup_ready_2 !== 1'b0 || lookup_data_2 !== 32'h0) begin errors++; $display("[TB] FAIL lookup_undone got %0b/%h expected 0/0", lookup_ready_2, lookup_data_2); end
        lookup_tag_2 = 4'd0;
        #1;
        checks++; if (lookup_ready_2 !== LK || lookup_data_2 !== (LK ? 32'h99 : 32'h0)) begin errors++; $display("[TB] FAIL lookup_stored got %0b/%h expected %0b/%h", lookup_ready_2, lookup_data_2, LK, LK ? 32'h99 : 32'h0); end
        cycle();
        wb_en = 0;
        #1;
        checks++; if (lookup_ready_1 !== LK || lookup_data_1 !== (LK ? 32'h1234 : 32'h0)) begin errors++; $display("[TB] FAIL lookup_after_wb got %0b/%h expected %0b/%h", lookup_ready_1, lookup_data_1, LK, LK ? 32'h1234 : 32'h0); end
        idle();
    endtask

    task automatic test_random();
        logic        r1, r2;
        logic [31:0] d1, d2;
        ent_t        h;
        bit          hv;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            idle();
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 99) == 0);
            alloc_en = ($urandom_range(0, 99) < 55);
            pc_in = $urandom; reg_write_en_in = 1'($urandom); reg_write_addr_in = 5'($urandom);
            is_delayslot_in = 1'($urandom); exception_type_in = 8'($urandom) & 8'h0F;
            wb_en = ($urandom_range(0, 99) < 60);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                wb_tag = 4'((head_tag + $urandom_range(0, mq.size() - 1)) % D);
            else
                wb_tag = 4'($urandom);
            wb_data = $urandom; wb_exception_type = 8'($urandom) & 8'hF0;
            commit_ack = ($urandom_range(0, 99) < 50);
            lookup_tag_1 = 4'($urandom); lookup_tag_2 = 4'($urandom);
            #1;
            hv = (mq.size() > 0) && mq[0].done;
            if (mq.size() > 0) h = mq[0];
            checks++; if (count !== 5'(mq.size())) begin errors++; $display("[TB] FAIL rnd_count got %0d expected %0d", count, mq.size()); end
            checks++; if (alloc_ready !== (mq.size() < D)) begin errors++; $display("[TB] FAIL rnd_alloc_ready got %0b expected %0b", alloc_ready, mq.size() < D); end
            checks++; if (alloc_tag !== 4'((head_tag + mq.size()) % D)) begin errors++; $display("[TB] FAIL rnd_alloc_tag got %0d expected %0d", alloc_tag, (head_tag + mq.size()) % D); end
            checks++; if (commit_valid !== hv) begin errors++; $display("[TB] FAIL rnd_commit_valid got %0b expected %0b", commit_valid, hv); end
            if (hv) begin
                checks++;
                if ({commit_pc, commit_data, commit_exception_type, commit_reg_write_en, commit_reg_write_addr, commit_is_delayslot}
                    !== {h.pc, h.data, h.exc, h.rwe, h.raddr, h.dly}) begin
                    errors++;
                    $display("[TB] FAIL rnd_commit_fields got %h/%h/%h expected %h/%h/%h", commit_pc, commit_data, commit_exception_type, h.pc, h.data, h.exc);
                end
            end else begin
                checks++;
                if ({commit_pc, commit_data, commit_exception_type, commit_reg_write_en, commit_reg_write_addr, commit_is_delayslot} !== 79'h0) begin
                    errors++;
                    $display("[TB] FAIL rnd_commit_zero got %h/%h/%h expected 0", commit_pc, commit_data, commit_exception_type);
                end
            end
            model_lookup(lookup_tag_1, r1, d1);
            model_lookup(lookup_tag_2, r2, d2);
            checks++; if (lookup_ready_1 !== r1 || lookup_data_1 !== d1) begin errors++; $display("[TB] FAIL rnd_lookup_1 got %0b/%h expected %0b/%h", lookup_ready_1, lookup_data_1, r1, d1); end
            checks++; if (lookup_ready_2 !== r2 || lookup_data_2 !== d2) begin errors++; $display("[TB] FAIL rnd_lookup_2 got %0b/%h expected %0b/%h", lookup_ready_2, lookup_data_2, r2, d2); end
            cycle();
        end
        idle();
    endtask

    initial begin
        idle();
        #2;
        test_reset();
        test_in_order();
        test_full_wrap();
        test_back_to_back();
        test_exception_or();
        test_flush();
        test_lookup();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
